// File: rtl/paddle_pot_emulator.sv
// Paddle potentiometer / 555 one-shot emulator: raises pad_out a position-dependent
// number of scan lines after the game lowers pad_en_n.
module paddle_pot_emulator #(
    parameter int unsigned LINE_OFFSET = 16,
    parameter int unsigned RANGE       = 224,
    parameter int unsigned SENS_SHIFT  = 0,
    parameter int unsigned POS_RESET   = 128
) (
    input  logic       clk_drv,
    input  logic       reset,
    input  logic       pad_en_n,
    input  logic       hsync,
    input  logic       mode,
    input  logic [7:0] paddle_pos,
    input  logic [7:0] delta,
    input  logic       delta_stb,
    output logic       pad_out,
    output logic [7:0] pos_out
);

    localparam int unsigned PW = 8;
    localparam int unsigned CW = 9;
    localparam int unsigned AW = 12;
    localparam int unsigned MW = 17;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CHARGE = 2'd1,
        FIRED  = 2'd2
    } state_t;

    state_t                state;
    logic                  hsync_d;
    logic [PW-1:0]         pos_acc;
    logic [CW-1:0]         line_cnt;
    logic [CW-1:0]         target_q;

    logic                  tick;
    logic signed [AW-1:0]  delta_ext;
    logic signed [AW-1:0]  delta_sh;
    logic signed [AW-1:0]  pos_sum;
    logic [PW-1:0]         pos_sat;
    logic [MW-1:0]         pos_prod;
    logic [CW-1:0]         target;
    logic [CW-1:0]         line_inc;

    // Line tick, relative-mode update with saturation, and sweep target
    always_comb begin
        tick      = hsync & ~hsync_d;
        delta_ext = {{(AW-PW){delta[PW-1]}}, delta};
        delta_sh  = delta_ext <<< SENS_SHIFT;
        pos_sum   = $signed({{(AW-PW){1'b0}}, pos_acc}) + delta_sh;
        if (pos_sum[AW-1]) begin
            pos_sat = '0;
        end else if (pos_sum > $signed(AW'(255))) begin
            pos_sat = '1;
        end else begin
            pos_sat = pos_sum[PW-1:0];
        end
        pos_prod = MW'(pos_acc) * MW'(RANGE);
        target   = CW'(LINE_OFFSET) + CW'(pos_prod >> 8);
        line_inc = (line_cnt == '1) ? line_cnt : line_cnt + CW'(1);
    end

    always_ff @(posedge clk_drv) begin
        if (reset) begin
            state    <= IDLE;
            pad_out  <= 1'b0;
            line_cnt <= '0;
            hsync_d  <= 1'b0;
            pos_acc  <= PW'(POS_RESET);
            target_q <= '0;
        end else begin
            hsync_d <= hsync;

            if (!mode) begin
                pos_acc <= paddle_pos;
            end else if (delta_stb) begin
                pos_acc <= pos_sat;
            end

            // Releasing the enable always wins, even over a tick in the same cycle
            if (pad_en_n) begin
                state    <= IDLE;
                pad_out  <= 1'b0;
                line_cnt <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        state    <= CHARGE;
                        target_q <= target;
                        line_cnt <= '0;
                        pad_out  <= 1'b0;
                    end
                    CHARGE: begin
                        if (tick) begin
                            line_cnt <= line_inc;
                            if (line_inc >= target_q) begin
                                state   <= FIRED;
                                pad_out <= 1'b1;
                            end
                        end
                    end
                    FIRED: begin
                        pad_out <= 1'b1;
                    end
                    default: begin
                        state    <= IDLE;
                        pad_out  <= 1'b0;
                        line_cnt <= '0;
                    end
                endcase
            end
        end
    end

    assign pos_out = pos_acc;

endmodule
